// File: rtl/motor_pwm_pkg.sv
// Shared types and helpers for the multi-channel motor PWM driver.
package motor_pwm_pkg;

  typedef enum logic [1:0] {
    StRun,
    StFilt,
    StTrip,
    StLatched
  } ch_state_t;

  localparam logic [1:0] SpeedOff = 2'd0;
  localparam logic [1:0] SpeedL1  = 2'd1;
  localparam logic [1:0] SpeedL2  = 2'd2;
  localparam logic [1:0] SpeedL3  = 2'd3;

  function automatic int unsigned speed_width(input logic [1:0] spd, input int unsigned l1,
                                              input int unsigned l2, input int unsigned l3);
    int unsigned w;
    case (spd)
      SpeedL1: w = l1;
      SpeedL2: w = l2;
      SpeedL3: w = l3;
      default: w = 0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/oc_guard.sv
// Single-channel over-current guard: glitch filter, timed retry, latch after too many trips.
module oc_guard
  import motor_pwm_pkg::*;
#(
  parameter int unsigned OC_FILTER  = 100000,
  parameter int unsigned RETRY_WAIT = 100000000,
  parameter int unsigned OC_RETRIES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic oc,
  input  logic fault_clr,
  output logic pwm_en,
  output logic fault
);

  localparam int unsigned FiltW  = $clog2(OC_FILTER + 1);
  localparam int unsigned WaitW  = $clog2(RETRY_WAIT + 1);
  localparam int unsigned RetryW = $clog2(OC_RETRIES + 2);
  localparam logic [FiltW-1:0]  FiltLast = FiltW'(OC_FILTER);
  localparam logic [WaitW-1:0]  WaitLast = WaitW'(RETRY_WAIT - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(OC_RETRIES);

  ch_state_t         state_q, state_d;
  logic [FiltW-1:0]  filt_q, filt_d;
  // Counts the post-trip wait in TRIP and the clean-run time in RUN.
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [RetryW-1:0] retry_q, retry_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      filt_q  <= '0;
      wait_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    wait_d  = wait_q;
    retry_d = retry_q;
    unique case (state_q)
      StRun: begin
        if (oc) begin
          wait_d = '0;
          if (OC_FILTER <= 1) begin
            state_d = StTrip;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d = StFilt;
            filt_d  = FiltW'(1);
          end
        end else if (wait_q == WaitLast) begin
          wait_d  = '0;
          retry_d = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StFilt: begin
        if (!oc) begin
          state_d = StRun;
          filt_d  = '0;
        end else if (filt_q + 1'b1 == FiltLast) begin
          state_d = StTrip;
          filt_d  = '0;
          wait_d  = '0;
          retry_d = retry_q + 1'b1;
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end
      StTrip: begin
        if (retry_q >= RetryMax) begin
          state_d = StLatched;
        end else if (wait_q == WaitLast) begin
          state_d = StRun;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StLatched: begin
        if (fault_clr) begin
          state_d = StRun;
          wait_d  = '0;
          retry_d = '0;
        end
      end
      default: state_d = StRun;
    endcase
  end

  assign pwm_en = (state_q == StRun) || (state_q == StFilt);
  assign fault  = (state_q == StLatched);

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Multi-channel soft-start motor PWM with per-channel over-current guard.
// Define PWM_BOOST_EN to add the boost input (speed 3 + boost ramps to 100% duty).
module motor_pwm_ctrl
  import motor_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_W      = 23,
  parameter int unsigned PERIOD     = 1666667,
  parameter int unsigned DUTY_L1    = 1583332,
  parameter int unsigned DUTY_L2    = 1583332,
  parameter int unsigned DUTY_L3    = 1333333,
  parameter int unsigned RAMP_STEP  = 166666,
  parameter int unsigned OC_FILTER  = 100000,
  parameter int unsigned RETRY_WAIT = 100000000,
  parameter int unsigned OC_RETRIES = 3
) (
  input  logic              clock,
  input  logic              reset,
`ifdef PWM_BOOST_EN
  input  logic              boost,
`endif
  input  logic [1:0]        speed,
  input  logic [NUM_CH-1:0] oc_in,
  input  logic              fault_clr,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] oc_led,
  output logic [NUM_CH-1:0] fault,
  output logic              period_tick
);

  logic [CNT_W-1:0]  cnt_q, cur_w_q, tgt_w;
  logic [CNT_W:0]    ramp_sum;
  logic [1:0]        speed_q;
  logic              wrap;
  logic [NUM_CH-1:0] ch_en;
`ifdef PWM_BOOST_EN
  logic              boost_q;
`endif

  assign wrap     = (cnt_q == CNT_W'(PERIOD - 1));
  assign ramp_sum = {1'b0, cur_w_q} + (CNT_W + 1)'(RAMP_STEP);

  always_comb begin
    tgt_w = CNT_W'(speed_width(speed_q, DUTY_L1, DUTY_L2, DUTY_L3));
`ifdef PWM_BOOST_EN
    if (speed_q == SpeedL3 && boost_q) tgt_w = CNT_W'(PERIOD);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      cur_w_q     <= '0;
      speed_q     <= SpeedOff;
      period_tick <= 1'b0;
      oc_led      <= '0;
      pwm_out     <= '0;
`ifdef PWM_BOOST_EN
      boost_q     <= 1'b0;
`endif
    end else begin
      speed_q     <= speed;
      oc_led      <= oc_in;
      period_tick <= wrap;
      cnt_q       <= wrap ? '0 : cnt_q + 1'b1;
`ifdef PWM_BOOST_EN
      boost_q     <= boost;
`endif
      // Width only moves at the wrap so a period never gets a runt pulse.
      if (wrap) begin
        if (tgt_w < cur_w_q) begin
          cur_w_q <= tgt_w;
        end else if (ramp_sum > {1'b0, tgt_w}) begin
          cur_w_q <= tgt_w;
        end else begin
          cur_w_q <= ramp_sum[CNT_W-1:0];
        end
      end
      pwm_out <= {NUM_CH{cnt_q < cur_w_q}} & ch_en;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    oc_guard #(
      .OC_FILTER (OC_FILTER),
      .RETRY_WAIT(RETRY_WAIT),
      .OC_RETRIES(OC_RETRIES)
    ) u_oc_guard (
      .clock    (clock),
      .reset    (reset),
      .oc       (oc_in[i]),
      .fault_clr(fault_clr),
      .pwm_en   (ch_en[i]),
      .fault    (fault[i])
    );
  end

endmodule

// File: tb/tb_motor_pwm_ctrl.sv
// Scoreboard bench for motor_pwm_ctrl with a shortened period and short fault timing.
module tb_motor_pwm_ctrl;

  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned CNT_W      = 23;
  localparam int unsigned PERIOD     = 100;
  localparam int unsigned DUTY_L1    = 25;
  localparam int unsigned DUTY_L2    = 50;
  localparam int unsigned DUTY_L3    = 75;
  localparam int unsigned RAMP_STEP  = 20;
  localparam int unsigned OC_FILTER  = 4;
  localparam int unsigned RETRY_WAIT = 20;
  localparam int unsigned OC_RETRIES = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [1:0]        speed = 2'd0;
  logic [NUM_CH-1:0] oc_in = '0;
  logic              fault_clr = 1'b0;
  logic [NUM_CH-1:0] pwm_out, oc_led, fault;
  logic              period_tick;

  int tests = 0;
  int fails = 0;

  // One expected pwm_out vector per counter value, pushed when a period is planned.
  logic [NUM_CH-1:0] sb_q[$];
  logic [NUM_CH-1:0] fault_hist[PERIOD+1];

  always #5 clock = ~clock;

  motor_pwm_ctrl #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .PERIOD    (PERIOD),
    .DUTY_L1   (DUTY_L1),
    .DUTY_L2   (DUTY_L2),
    .DUTY_L3   (DUTY_L3),
    .RAMP_STEP (RAMP_STEP),
    .OC_FILTER (OC_FILTER),
    .RETRY_WAIT(RETRY_WAIT),
    .OC_RETRIES(OC_RETRIES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
`ifdef PWM_BOOST_EN
    .boost      (1'b0),
`endif
    .speed      (speed),
    .oc_in      (oc_in),
    .fault_clr  (fault_clr),
    .pwm_out    (pwm_out),
    .oc_led     (oc_led),
    .fault      (fault),
    .period_tick(period_tick)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_widths(input int w0, input int w1);
    for (int k = 0; k < int'(PERIOD); k++) sb_q.push_back({k < w1, k < w0});
  endtask

  // Starts right after a tick sample and ends on the next tick sample.
  task automatic collect_period(output int bad, output int first_k,
                                output logic [NUM_CH-1:0] first_act,
                                output logic [NUM_CH-1:0] first_exp, output logic tick_end);
    logic [NUM_CH-1:0] e;
    bad = 0;
    first_k = -1;
    first_act = '0;
    first_exp = '0;
    for (int k = 0; k < int'(PERIOD); k++) begin
      step();
      fault_hist[k+1] = fault;
      if (sb_q.size() == 0) e = 'x;
      else e = sb_q.pop_front();
      if (pwm_out !== e) begin
        if (bad == 0) begin
          first_k = k;
          first_act = pwm_out;
          first_exp = e;
        end
        bad++;
      end
    end
    tick_end = period_tick;
  endtask

  task automatic sync_tick(output int n, output logic saw_pwm);
    n = 0;
    saw_pwm = 1'b0;
    do begin
      step();
      n++;
      if (pwm_out !== '0) saw_pwm = 1'b1;
    end while (period_tick !== 1'b1 && n < 2 * int'(PERIOD));
  endtask

  task automatic test_reset();
    logic dirty;
    oc_in = 2'b11;
    repeat (3) step();
    tests++;
    if ({pwm_out, oc_led, fault, period_tick} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got pwm=%b led=%b fault=%b tick=%b, want all 0",
               pwm_out, oc_led, fault, period_tick);
    end
    oc_in = '0;
    reset = 1'b0;
    dirty = 1'b0;
    repeat (30) begin
      step();
      if (pwm_out !== '0 || period_tick !== 1'b0 || fault !== '0) dirty = 1'b1;
    end
    tests++;
    if (dirty !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: activity seen after release, want none");
    end
  endtask

  task automatic test_soft_start();
    int n, bad, fk;
    logic saw, te;
    logic [NUM_CH-1:0] fa, fe;
    int widths[3] = '{20, 40, 50};
    speed = 2'd2;
    sync_tick(n, saw);
    tests++;
    if (n !== 70 || saw !== 1'b0) begin
      fails++;
      $display("FAIL first_wrap: got %0d cycles pwm_seen=%b, want 70 and 0", n, saw);
    end
    foreach (widths[p]) push_widths(widths[p], widths[p]);
    foreach (widths[p]) begin
      collect_period(bad, fk, fa, fe, te);
      tests++;
      if (bad !== 0 || te !== 1'b1) begin
        fails++;
        $display("FAIL soft_start p%0d: %0d bad, first cnt %0d got %b want %b, tick=%b",
                 p, bad, fk, fa, fe, te);
      end
    end
  endtask

  task automatic test_drop();
    int bad, fk;
    logic te;
    logic [NUM_CH-1:0] fa, fe;
    speed = 2'd1;
    push_widths(50, 50);
    push_widths(25, 25);
    for (int p = 0; p < 2; p++) begin
      collect_period(bad, fk, fa, fe, te);
      tests++;
      if (bad !== 0 || te !== 1'b1) begin
        fails++;
        $display("FAIL drop p%0d: %0d bad, first cnt %0d got %b want %b, tick=%b",
                 p, bad, fk, fa, fe, te);
      end
    end
  endtask

  task automatic test_glitch_filter();
    int bad, fk;
    logic te;
    logic [NUM_CH-1:0] fa, fe;
    push_widths(25, 25);
    fork
      collect_period(bad, fk, fa, fe, te);
      begin
        repeat (5) step();
        oc_in[0] = 1'b1;
        step();
        tests++;
        if (oc_led !== 2'b01) begin
          fails++;
          $display("FAIL oc_led: got %b want 01", oc_led);
        end
        repeat (2) step();
        oc_in[0] = 1'b0;
      end
    join
    tests++;
    if (bad !== 0 || te !== 1'b1 || fault_hist[PERIOD] !== '0) begin
      fails++;
      $display("FAIL glitch: %0d bad, first cnt %0d got %b want %b, fault=%b",
               bad, fk, fa, fe, fault_hist[PERIOD]);
    end
  endtask

  task automatic test_ramp_to_l3();
    int bad, fk;
    logic te;
    logic [NUM_CH-1:0] fa, fe;
    int widths[4] = '{25, 45, 65, 75};
    speed = 2'd3;
    foreach (widths[p]) push_widths(widths[p], widths[p]);
    foreach (widths[p]) begin
      collect_period(bad, fk, fa, fe, te);
      tests++;
      if (bad !== 0 || te !== 1'b1) begin
        fails++;
        $display("FAIL ramp_l3 p%0d: %0d bad, first cnt %0d got %b want %b", p, bad, fk, fa, fe);
      end
    end
  endtask

  task automatic test_retry_latch();
    int bad, fk;
    logic te;
    logic [NUM_CH-1:0] fa, fe;
    oc_in[0] = 1'b1;
    // Filter 4 cycles, off 20, one short re-run, second trip, then latch.
    for (int k = 0; k < int'(PERIOD); k++)
      sb_q.push_back({k < 75, (k <= 3) || (k >= 24 && k <= 27)});
    fork
      collect_period(bad, fk, fa, fe, te);
      begin
        repeat (29) step();
        oc_in[0] = 1'b0;
      end
    join
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL retry_pwm: %0d bad, first cnt %0d got %b want %b", bad, fk, fa, fe);
    end
    tests++;
    if (fault_hist[28] !== 2'b00 || fault_hist[29] !== 2'b01 || fault_hist[PERIOD] !== 2'b01) begin
      fails++;
      $display("FAIL latch_fault: got %b/%b/%b want 00/01/01",
               fault_hist[28], fault_hist[29], fault_hist[PERIOD]);
    end
  endtask

  task automatic test_fault_clear();
    int bad, fk;
    logic te;
    logic [NUM_CH-1:0] fa, fe;
    push_widths(0, 75);
    collect_period(bad, fk, fa, fe, te);
    tests++;
    if (bad !== 0 || fault_hist[PERIOD] !== 2'b01) begin
      fails++;
      $display("FAIL latched_hold: %0d bad, got %b want %b, fault=%b", bad, fa, fe,
               fault_hist[PERIOD]);
    end
    fault_clr = 1'b1;
    for (int k = 0; k < int'(PERIOD); k++) sb_q.push_back({k < 75, k >= 1 && k <= 74});
    fork
      collect_period(bad, fk, fa, fe, te);
      begin
        step();
        fault_clr = 1'b0;
      end
    join
    tests++;
    if (bad !== 0 || fault_hist[1] !== 2'b00) begin
      fails++;
      $display("FAIL clear: %0d bad, first cnt %0d got %b want %b, fault=%b",
               bad, fk, fa, fe, fault_hist[1]);
    end
    push_widths(75, 75);
    fork
      collect_period(bad, fk, fa, fe, te);
      begin
        repeat (10) step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
      end
    join
    tests++;
    if (bad !== 0 || fault_hist[20] !== 2'b00 || fault_hist[PERIOD] !== 2'b00) begin
      fails++;
      $display("FAIL clr_in_run: %0d bad, got %b want %b, fault=%b", bad, fa, fe, fault_hist[20]);
    end
  endtask

  task automatic test_async_reset();
    int n, bad, fk;
    logic saw, te;
    logic [NUM_CH-1:0] fa, fe;
    oc_in[1] = 1'b1;
    repeat (60) step();
    oc_in[1] = 1'b0;
    tests++;
    if (pwm_out !== 2'b01 || fault !== 2'b10) begin
      fails++;
      $display("FAIL pre_reset: got pwm=%b fault=%b want 01 and 10", pwm_out, fault);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (pwm_out !== '0 || fault !== '0 || period_tick !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got pwm=%b fault=%b tick=%b want 0", pwm_out, fault,
               period_tick);
    end
    repeat (3) step();
    reset = 1'b0;
    sync_tick(n, saw);
    tests++;
    if (n !== int'(PERIOD) || saw !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_wrap: got %0d cycles pwm_seen=%b want %0d and 0", n, saw, PERIOD);
    end
    push_widths(20, 20);
    push_widths(40, 40);
    for (int p = 0; p < 2; p++) begin
      collect_period(bad, fk, fa, fe, te);
      tests++;
      if (bad !== 0 || te !== 1'b1) begin
        fails++;
        $display("FAIL reramp p%0d: %0d bad, first cnt %0d got %b want %b", p, bad, fk, fa, fe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_drop();
    test_glitch_filter();
    test_ramp_to_l3();
    test_retry_latch();
    test_fault_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/motor_pwm_ctrl.md
Name: motor_pwm_ctrl

Overview:
- Multi-channel PWM driver for the rover's motor enables (ENA/ENB and beyond); the generalised successor of the single-width speed PWM.
- Maps the 2-bit speed level from the colour-sensor state machine to a duty width.
- Ramps the width up gradually (soft start) on period boundaries only.
- Runs a per-channel over-current filter/retry/latch FSM driven by the driver-board sense pins; sits between the colour-sensor state machine and the motor driver pins.

Parameters:
- NUM_CH, 2, number of motor channels.
- CNT_W, 23, period counter/width bit width.
- PERIOD, 1666667, clock cycles per PWM period; counter runs 0..PERIOD-1.
- DUTY_L1, 1583332, width for speed 1.
- DUTY_L2, 1583332, width for speed 2.
- DUTY_L3, 1333333, width for speed 3.
- RAMP_STEP, 166666, maximum width increase per period.
- OC_FILTER, 100000, consecutive oc cycles required to trip.
- RETRY_WAIT, 100000000, cycles off after a trip; also the clean-run time that clears the retry count.
- OC_RETRIES, 3, trips allowed before latching.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- speed, input, 2, speed level 0..3.
- oc_in, input, NUM_CH, per-channel over-current sense; high = over-current.
- fault_clr, input, 1, single-cycle pulse that clears latched faults.
- pwm_out, output, NUM_CH, motor enable PWM.
- oc_led, output, NUM_CH, registered copy of oc_in.
- fault, output, NUM_CH, channel latched off.
- period_tick, output, 1, one-cycle pulse when the counter wraps.

Behaviour:
- Reset (async, active-high) values:
  - All outputs 0.
  - Counter 0; current width cur_w 0.
  - All channel FSMs in RUN with retry count 0.
- Counter:
  - Increments every clock; at PERIOD-1 wraps to 0.
  - period_tick is registered and is 1 during the cycle in which the counter equals 0.
- Target width tgt_w from speed: 0 -> 0, 1 -> DUTY_L1, 2 -> DUTY_L2, 3 -> DUTY_L3.
  - speed is sampled every cycle, but tgt_w applies only at a wrap.
- Width update, at the wrap cycle only:
  - If tgt_w < cur_w: cur_w <= tgt_w (immediate drop, no down-ramp).
  - Otherwise: cur_w <= min(cur_w + RAMP_STEP, tgt_w).
  - The sum is computed in CNT_W+1 bits, so there is no overflow.
  - A width never changes mid-period, so there are no runt pulses.
- pwm_out[i] is registered and equals (counter < cur_w) && state[i]==RUN.
  - One cycle of latency from the counter value.
  - cur_w >= PERIOD gives 100% duty; cur_w 0 gives a constant 0.
- oc_led[i] <= oc_in[i] every cycle.
- Per-channel FSM:
  - RUN:
    - oc high -> FILT, filter count 1.
    - Clean-cycle counter increments while oc is low; when it reaches RETRY_WAIT, retry count <= 0.
  - FILT:
    - oc high -> count+1; on reaching OC_FILTER -> TRIP and retry count+1.
    - oc low -> back to RUN, filter count 0.
    - pwm is still driven during FILT.
  - TRIP:
    - pwm forced 0, wait counter runs.
    - If the retry count equals OC_RETRIES -> LATCHED immediately (next cycle).
    - Otherwise, after RETRY_WAIT cycles -> RUN, regardless of oc.
  - LATCHED:
    - pwm 0, fault[i] = 1.
    - fault_clr -> RUN, retry count 0, fault 0 the next cycle.
    - fault_clr is ignored in all other states.
- Simultaneous events:
  - fault_clr in the same cycle as a new trip: the trip wins.
  - Channels are fully independent.
- Reset mid-period or mid-retry returns everything to reset values with no residual pulse.

Optional Feature:
- PWM_BOOST_EN: adds input boost (1 bit).
  - With the macro defined: speed==3 && boost gives tgt_w = PERIOD (100% duty), still ramped.
  - Without it: no boost port, and speed 3 always uses DUTY_L3.

Decomposition:
- Package motor_pwm_pkg holds:
  - The channel state enum (RUN, FILT, TRIP, LATCHED).
  - The speed encoding constants.
  - A function mapping speed to width.
- One sub-module, oc_guard: a single channel's FSM with its filter, wait and retry counters, instantiated NUM_CH times in a generate loop.
- The counter and ramp logic stay in the top level.

Test Plan:
Bench parameters: PERIOD=100, DUTY_L1=25, DUTY_L2=50, DUTY_L3=75, RAMP_STEP=20, OC_FILTER=4, RETRY_WAIT=20, OC_RETRIES=2.
1. Soft start: speed 0 -> 2 mid-period -> cur_w becomes 20, 40, 50 on the next three wraps; pwm_out high for exactly that many cycles per period.
2. Drop: at width 50, set speed=1 -> the next period is 25 cycles high, with no partial pulse before the wrap.
3. Glitch filter: oc_in[0] high for 3 cycles -> no trip and pwm unaffected; channel 1 unaffected throughout.
4. Retry: oc_in[0] held high -> trip after 4 cycles, pwm 0 for 20 cycles, re-runs, trips again -> LATCHED with fault[0]=1.
5. Clear: fault_clr pulse while latched, oc low -> fault[0]=0 next cycle, pwm resumes at the current width; fault_clr in RUN is a no-op.
6. Reset: assert reset asynchronously mid-pulse -> pwm_out, fault and period_tick go 0 immediately; ramp restarts from 0 after release.
